// File: rtl/fwd_ctrl.sv
// Purpose : EX-stage operand forwarding selects and one-cycle load-use stall for a 5-stage pipeline.
// Latency : selects are registered (computed in ID, valid in EX); stall_o is combinational from ID and EX.
// Backpressure: hold_i freezes every slot, select and counter; stall_o holds IF/ID and injects an EX bubble.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_valid_i                  ID holds a real instruction
//   id_rs_i / id_rt_i           ID source registers, qualified by id_use_rs_i / id_use_rt_i
//   id_rd_i, id_regwrite_i      ID destination register and its write enable
//   id_memread_i                ID instruction is a load
//   hold_i                      global freeze (has priority over flush_i)
//   flush_i                     kill the instruction in ID
//   fwd_a_sel_o / fwd_b_sel_o   00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB-hold
//   stall_o                     load-use stall toward IF/ID
// Optional (FWD_STATS_EN defined):
//   stat_clr_i                  synchronous clear of both counters
//   stat_fwd_cnt_o              non-00 selects registered (A and B counted separately)
//   stat_stall_cnt_o            cycles with stall_o & !hold_i
// Both counters saturate at all-ones and freeze while hold_i is high.
module fwd_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stall_o
`ifdef FWD_STATS_EN
    ,
    input  logic              stat_clr_i,
    output logic [CNT_W-1:0]  stat_fwd_cnt_o,
    output logic [CNT_W-1:0]  stat_stall_cnt_o
`endif
);

    // In-flight destination tracking. Only EX needs memread (load-use check).
    logic              ex_vld, ex_rw, ex_mr;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_vld, mem_rw;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_vld, wb_rw;
    logic [REG_AW-1:0] wb_rd;

    logic              load_ex;
    logic [1:0]        a_sel_nxt;
    logic [1:0]        b_sel_nxt;

    function automatic logic hit(input logic              vld,
                                 input logic              rw,
                                 input logic [REG_AW-1:0] rd,
                                 input logic [REG_AW-1:0] src,
                                 input logic              use_src);
        return vld & rw & (rd != '0) & (rd == src) & use_src;
    endfunction

    // Nearest producer wins; r0 never matches because rd != 0 is required.
    function automatic logic [1:0] sel_for(input logic [REG_AW-1:0] src,
                                           input logic              use_src);
        logic [1:0] s;
        s = 2'b00;
        if (hit(ex_vld, ex_rw, ex_rd, src, use_src))
            s = 2'b01;
        else if (hit(mem_vld, mem_rw, mem_rd, src, use_src))
            s = 2'b10;
        else if (hit(wb_vld, wb_rw, wb_rd, src, use_src))
            s = 2'b11;
        return s;
    endfunction

    always_comb begin
        stall_o   = 1'b0;
        load_ex   = 1'b0;
        a_sel_nxt = 2'b00;
        b_sel_nxt = 2'b00;

        // A load in EX has no data until MEM; one bubble lets the consumer pick it up via select 10.
        // Deliberately not gated by hold_i: the stall request stays visible across a freeze.
        stall_o = id_valid_i & ~flush_i & ex_vld & ex_mr & (ex_rd != '0) &
                  (((ex_rd == id_rs_i) & id_use_rs_i) | ((ex_rd == id_rt_i) & id_use_rt_i));

        load_ex = id_valid_i & ~stall_o & ~flush_i;
        if (load_ex) begin
            a_sel_nxt = sel_for(id_rs_i, id_use_rs_i);
            b_sel_nxt = sel_for(id_rt_i, id_use_rt_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_vld      <= 1'b0;
            ex_rw       <= 1'b0;
            ex_mr       <= 1'b0;
            ex_rd       <= '0;
            mem_vld     <= 1'b0;
            mem_rw      <= 1'b0;
            mem_rd      <= '0;
            wb_vld      <= 1'b0;
            wb_rw       <= 1'b0;
            wb_rd       <= '0;
            fwd_a_sel_o <= 2'b00;
            fwd_b_sel_o <= 2'b00;
        end else if (!hold_i) begin
            wb_vld      <= mem_vld;
            wb_rw       <= mem_rw;
            wb_rd       <= mem_rd;
            mem_vld     <= ex_vld;
            mem_rw      <= ex_rw;
            mem_rd      <= ex_rd;
            // Bubble = valid cleared; the other fields are don't-care when invalid.
            ex_vld      <= load_ex;
            ex_rw       <= id_regwrite_i;
            ex_mr       <= id_memread_i;
            ex_rd       <= id_rd_i;
            fwd_a_sel_o <= a_sel_nxt;
            fwd_b_sel_o <= b_sel_nxt;
        end
    end

`ifdef FWD_STATS_EN
    logic [1:0]     fwd_inc;
    logic [CNT_W:0] fwd_sum;

    always_comb begin
        fwd_inc = {1'b0, (a_sel_nxt != 2'b00)} + {1'b0, (b_sel_nxt != 2'b00)};
        fwd_sum = {1'b0, stat_fwd_cnt_o} + {{(CNT_W-1){1'b0}}, fwd_inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fwd_cnt_o   <= '0;
            stat_stall_cnt_o <= '0;
        end else if (stat_clr_i) begin
            stat_fwd_cnt_o   <= '0;
            stat_stall_cnt_o <= '0;
        end else if (!hold_i) begin
            // Carry out of the widened sum means we crossed all-ones: pin there.
            stat_fwd_cnt_o <= fwd_sum[CNT_W] ? {CNT_W{1'b1}} : fwd_sum[CNT_W-1:0];
            if (stall_o && (stat_stall_cnt_o != {CNT_W{1'b1}}))
                stat_stall_cnt_o <= stat_stall_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// Self-checking bench for fwd_ctrl: directed pipeline scenarios followed by random traffic,
// all checked against a model that tracks the last three instructions sent to EX by distance.
module tb_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid_i;
    logic [4:0] id_rs_i, id_rt_i, id_rd_i;
    logic       id_use_rs_i, id_use_rt_i, id_regwrite_i, id_memread_i;
    logic       hold_i, flush_i;
    logic [1:0] fwd_a_sel_o, fwd_b_sel_o;
    logic       stall_o;
`ifdef FWD_STATS_EN
    logic        stat_clr_i;
    logic [15:0] stat_fwd_cnt_o, stat_stall_cnt_o;
`endif

    fwd_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_use_rs_i(id_use_rs_i), .id_use_rt_i(id_use_rt_i),
        .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .hold_i(hold_i), .flush_i(flush_i),
        .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o), .stall_o(stall_o)
`ifdef FWD_STATS_EN
        , .stat_clr_i(stat_clr_i), .stat_fwd_cnt_o(stat_fwd_cnt_o),
        .stat_stall_cnt_o(stat_stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: h[d] is the instruction that entered EX d+1 cycles ago (d = 0..2).
    // A producer at distance k supplies select k; a load at distance 1 forces a stall.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       rw;
        bit       mr;
    } ent_t;

    ent_t     h[3];
    bit [1:0] m_a, m_b;
    int       m_fwd, m_stl;
    logic     clr_drv = 1'b0;
    logic     obs_stall;

    function automatic bit [1:0] m_sel(input bit [4:0] src, input bit u);
        if (!u || src == 0) return 2'd0;
        for (int d = 0; d < 3; d++)
            if (h[d].v && h[d].rw && h[d].rd == src) return 2'(d + 1);
        return 2'd0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) h[d] = '{1'b0, 5'd0, 1'b0, 1'b0};
        m_a = 0; m_b = 0; m_fwd = 0; m_stl = 0;
    endtask

    // One cycle: called at posedge+1, drives ID, checks stall, advances model, checks selects.
    task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic hold, input logic flush);
        bit       ms;
        bit [1:0] na, nb;
        ent_t     e;
        id_valid_i = v; id_rs_i = rs; id_rt_i = rt; id_use_rs_i = urs; id_use_rt_i = urt;
        id_rd_i = rd; id_regwrite_i = rw; id_memread_i = mr; hold_i = hold; flush_i = flush;
`ifdef FWD_STATS_EN
        stat_clr_i = clr_drv;
`endif
        #2;
        ms = v && !flush && h[0].v && h[0].mr && h[0].rd != 0 &&
             ((h[0].rd == rs && urs) || (h[0].rd == rt && urt));
        obs_stall = stall_o;
        chk("stall", {31'd0, stall_o}, {31'd0, ms});
        na = 0; nb = 0;
        if (!hold) begin
            if (v && !ms && !flush) begin
                e  = '{1'b1, rd, rw, mr};
                na = m_sel(rs, urs);
                nb = m_sel(rt, urt);
            end else begin
                e = '{1'b0, 5'd0, 1'b0, 1'b0};
            end
        end
        if (clr_drv) begin
            m_fwd = 0; m_stl = 0;
        end else if (!hold) begin
            m_fwd = m_fwd + int'(na != 0) + int'(nb != 0);
            if (m_fwd > 65535) m_fwd = 65535;
            if (ms && m_stl < 65535) m_stl++;
        end
        if (!hold) begin
            h[2] = h[1]; h[1] = h[0]; h[0] = e;
            m_a = na; m_b = nb;
        end
        @(posedge clk); #1;
        chk("sel_a", {30'd0, fwd_a_sel_o}, {30'd0, m_a});
        chk("sel_b", {30'd0, fwd_b_sel_o}, {30'd0, m_b});
`ifdef FWD_STATS_EN
        chk("stat_fwd", {16'd0, stat_fwd_cnt_o}, m_fwd);
        chk("stat_stall", {16'd0, stat_stall_cnt_o}, m_stl);
`endif
    endtask

    task automatic ins(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic [4:0] rd, input logic rw, input logic mr);
        step(1'b1, rs, rt, urs, urt, rd, rw, mr, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Called between edges; checks outputs while reset is asserted, releases before the next edge.
    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_a"}, {30'd0, fwd_a_sel_o}, 32'd0);
        chk({tag, "_b"}, {30'd0, fwd_b_sel_o}, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
        model_reset();
`ifdef FWD_STATS_EN
        chk({tag, "_sfwd"}, {16'd0, stat_fwd_cnt_o}, 32'd0);
        chk({tag, "_sstl"}, {16'd0, stat_stall_cnt_o}, 32'd0);
`endif
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid_i = 0; id_rs_i = 0; id_rt_i = 0; id_use_rs_i = 0; id_use_rt_i = 0;
        id_rd_i = 0; id_regwrite_i = 0; id_memread_i = 0; hold_i = 0; flush_i = 0;
`ifdef FWD_STATS_EN
        stat_clr_i = 0;
`endif
        model_reset();
        #3;
        chk("rst_a", {30'd0, fwd_a_sel_o}, 32'd0);
        chk("rst_b", {30'd0, fwd_b_sel_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back ALU: add r3,r1,r2 ; sub r4,r3,r5
        ins(5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
        ins(5'd3, 5'd5, 1, 1, 5'd4, 1, 0);
        chk("b2b_a", {30'd0, fwd_a_sel_o}, 32'd1);
        chk("b2b_b", {30'd0, fwd_b_sel_o}, 32'd0);

        // Producer of r7, n fillers, then reader: distance n+1 -> select n+1, beyond 3 -> 00.
        for (int n = 0; n < 4; n++) begin
            drain();
            ins(5'd0, 5'd0, 0, 0, 5'd7, 1, 0);
            for (int f = 0; f < n; f++) ins(5'd0, 5'd0, 0, 0, 5'd1, 1, 0);
            ins(5'd7, 5'd0, 1, 0, 5'd8, 1, 0);
            chk($sformatf("dist%0d", n + 1), {30'd0, fwd_a_sel_o}, (n < 3) ? n + 1 : 0);
        end

        // Priority: r9 written in WB and in EX -> nearest (01). r0 never forwards.
        drain();
        ins(5'd0, 5'd0, 0, 0, 5'd9, 1, 0);
        ins(5'd0, 5'd0, 0, 0, 5'd1, 1, 0);
        ins(5'd0, 5'd0, 0, 0, 5'd9, 1, 0);
        ins(5'd9, 5'd9, 1, 1, 5'd10, 1, 0);
        chk("prio_a", {30'd0, fwd_a_sel_o}, 32'd1);
        chk("prio_b", {30'd0, fwd_b_sel_o}, 32'd1);
        ins(5'd0, 5'd0, 0, 0, 5'd0, 1, 0);
        ins(5'd0, 5'd0, 1, 1, 5'd11, 1, 0);
        chk("r0_a", {30'd0, fwd_a_sel_o}, 32'd0);
        chk("r0_b", {30'd0, fwd_b_sel_o}, 32'd0);

        // Hold three cycles with a reader waiting in ID: everything frozen, then resumes.
        drain();
        ins(5'd0, 5'd0, 0, 0, 5'd7, 1, 0);
        ins(5'd7, 5'd0, 1, 0, 5'd8, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd0, 5'd7, 0, 1, 5'd12, 1, 0, 1'b1, 1'b0);
            chk("hold_a", {30'd0, fwd_a_sel_o}, 32'd1);
            chk("hold_b", {30'd0, fwd_b_sel_o}, 32'd0);
        end
        ins(5'd0, 5'd7, 0, 1, 5'd12, 1, 0);
        chk("post_hold_b", {30'd0, fwd_b_sel_o}, 32'd2);

        // Flush while a load-use condition is present: no stall, bubble into EX.
        drain();
        ins(5'd0, 5'd0, 0, 0, 5'd2, 1, 1);
        step(1'b1, 5'd2, 5'd2, 1, 1, 5'd6, 1, 0, 1'b0, 1'b1);
        chk("flush_stall", {31'd0, obs_stall}, 32'd0);
        chk("flush_a", {30'd0, fwd_a_sel_o}, 32'd0);
        chk("flush_b", {30'd0, fwd_b_sel_o}, 32'd0);

        // Reset in the middle of a stall.
        ins(5'd0, 5'd0, 0, 0, 5'd2, 1, 1);
        id_valid_i = 1; id_rs_i = 5'd2; id_use_rs_i = 1; id_flush_clear();
        #1;
        chk("pre_rst_stall", {31'd0, stall_o}, 32'd1);
        reset_pulse("midrst");

        // Load-use: lw r2 ; add r6,r2,r2 -> one stall cycle, bubble, then both selects 10.
        ins(5'd0, 5'd0, 0, 0, 5'd2, 1, 1);
        ins(5'd2, 5'd2, 1, 1, 5'd6, 1, 0);
        chk("lu_stall", {31'd0, obs_stall}, 32'd1);
        chk("lu_bubble_a", {30'd0, fwd_a_sel_o}, 32'd0);
        ins(5'd2, 5'd2, 1, 1, 5'd6, 1, 0);
        chk("lu_nostall", {31'd0, obs_stall}, 32'd0);
        chk("lu_a", {30'd0, fwd_a_sel_o}, 32'd2);
        chk("lu_b", {30'd0, fwd_b_sel_o}, 32'd2);
`ifdef FWD_STATS_EN
        chk("lu_sstl", {16'd0, stat_stall_cnt_o}, 32'd1);
        chk("lu_sfwd", {16'd0, stat_fwd_cnt_o}, 32'd2);
`endif

        // Random traffic over a small register set so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            clr_drv = ($urandom_range(0, 63) == 0);
            step($urandom_range(0, 7) != 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end
        clr_drv = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic id_flush_clear();
        id_rt_i = 5'd0; id_use_rt_i = 0; flush_i = 0; hold_i = 0;
    endtask

endmodule
